// File: rtl/sim_pkg.sv
// sim_pkg: sequencer state encodings and default grid dimensions shared by the
// sim_sequencer slice.
package sim_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        SCAN      = 3'd2,
        DONE      = 3'd3,
        PAUSED    = 3'd4
    } seq_state_t;
    localparam int GRID_W_DEF = 160;
    localparam int GRID_H_DEF = 120;
endpackage

// File: rtl/sim_sequencer_if.sv
// sim_sequencer_if: write-location bus between the sequencer (master) and the
// cell environment (slave).
interface sim_sequencer_if #(
    parameter int GRID_W = sim_pkg::GRID_W_DEF,
    parameter int GRID_H = sim_pkg::GRID_H_DEF
);
    logic                      env_ready;
    logic [$clog2(GRID_W)-1:0] writeLoc_x;
    logic [$clog2(GRID_H)-1:0] writeLoc_y;
    logic                      write_flag;
    logic                      hold_locs;
    modport master (input env_ready, output writeLoc_x, writeLoc_y, write_flag, hold_locs);
    modport slave  (output env_ready, input writeLoc_x, writeLoc_y, write_flag, hold_locs);
endinterface

// File: rtl/tick_divider.sv
// tick_divider: counts 0..factor-1 while enabled and pulses tick on the
// terminal count; factor 0 behaves as 1, count is frozen while disabled.
module tick_divider #(
    parameter int FACTOR_W = 26
) (
    input  logic                Clk,
    input  logic                RESET_SIM_N,
    input  logic                enable,
    input  logic [FACTOR_W-1:0] factor,
    output logic                tick
);
    logic [FACTOR_W-1:0] cnt;
    logic [FACTOR_W-1:0] last;
    assign last = (factor == '0) ? '0 : factor - FACTOR_W'(1);
    // >= so a factor lowered mid-count still terminates at once
    assign tick = enable && (cnt >= last);
    always_ff @(posedge Clk) begin
        if (!RESET_SIM_N) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + FACTOR_W'(1);
    end
endmodule

// File: rtl/sim_sequencer.sv
// sim_sequencer: paces raster sweeps of the cell grid on game ticks.
// Build macro SIM_SEQ_STEP_EN enables pause/single-step; otherwise both are ignored.
module sim_sequencer
    import sim_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int FACTOR_W = 26,
    parameter int GEN_W    = 16
) (
    input  logic                Clk,
    input  logic                RESET_SIM_N,
    input  logic                run,
    input  logic                pause,
    input  logic                step_req,
    input  logic [FACTOR_W-1:0] tick_factor,
    sim_sequencer_if.master     bus,
    output logic                sweep_done,
    output logic [GEN_W-1:0]    generation,
    output logic                overrun,
    output logic [2:0]          seq_state
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

    seq_state_t state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic stepping;
    logic tick;
    logic write_flag;
    logic pause_en;
    logic step_en;

`ifdef SIM_SEQ_STEP_EN
    assign pause_en = pause;
    assign step_en  = step_req;
`else
    logic unused_ctl;
    assign pause_en   = 1'b0;
    assign step_en    = 1'b0;
    assign unused_ctl = ^{pause, step_req};
`endif

    tick_divider #(.FACTOR_W(FACTOR_W)) u_div (
        .Clk         (Clk),
        .RESET_SIM_N (RESET_SIM_N),
        .enable      (state == WAIT_TICK || state == SCAN),
        .factor      (tick_factor),
        .tick        (tick)
    );

    assign write_flag     = (state == SCAN) && bus.env_ready;
    assign bus.write_flag = write_flag;
    assign bus.hold_locs  = !write_flag;
    assign bus.writeLoc_x = x;
    assign bus.writeLoc_y = y;
    assign sweep_done     = (state == DONE);
    assign seq_state      = state;

    always_ff @(posedge Clk) begin
        if (!RESET_SIM_N) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            stepping   <= 1'b0;
            generation <= '0;
            overrun    <= 1'b0;
        end else begin
            if (tick && state == SCAN) overrun <= 1'b1;
            // a sweep that reached DONE is complete even if run drops now
            if (state == DONE) generation <= generation + GEN_W'(1);
            if (!run) begin
                state <= IDLE;
                x     <= '0;
                y     <= '0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_TICK;
                    WAIT_TICK: begin
                        if (tick) begin
                            state    <= SCAN;
                            x        <= '0;
                            y        <= '0;
                            stepping <= 1'b0;
                        end else if (pause_en) begin
                            state <= PAUSED;
                        end
                    end
                    SCAN: begin
                        if (write_flag) begin
                            x <= (x == X_LAST) ? '0 : x + XW'(1);
                            if (x == X_LAST) y <= (y == Y_LAST) ? '0 : y + YW'(1);
                            if (x == X_LAST && y == Y_LAST) state <= DONE;
                        end
                    end
                    DONE: state <= (pause_en || stepping) ? PAUSED : WAIT_TICK;
                    PAUSED: begin
                        if (step_en) begin
                            state    <= SCAN;
                            x        <= '0;
                            y        <= '0;
                            stepping <= 1'b1;
                        end else if (!pause_en) begin
                            state <= WAIT_TICK;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
